// File: rtl/cx_mac_cxu.sv
// cx_mac_cxu: iterative multiply-accumulate CXU with registered response and status.
// Define CX_MAC_STATE_CTX_EN for four accumulators selected by cx_state_id; otherwise a single shared one.
module cx_mac_cxu #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cxu_valid,
    input  logic [2:0]  cxu_func,
    input  logic [31:0] cxu_data0,
    input  logic [31:0] cxu_data1,
    input  logic [1:0]  cx_state_id,
    output logic        cxu_ready,
    output logic [31:0] cxu_response,
    output logic [3:0]  cxu_status
);
    localparam int CYC = 32 / BITS_PER_CYCLE;
`ifdef CX_MAC_STATE_CTX_EN
    localparam int NCTX = 4;
    localparam int SW = 2;
    logic [SW-1:0] sid_in;
    assign sid_in = cx_state_id;
`else
    localparam int NCTX = 1;
    localparam int SW = 1;
    logic [SW-1:0] sid_in;
    logic unused_sid;
    assign sid_in = 1'b0;
    assign unused_sid = ^cx_state_id;
`endif
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state_q;
    logic [2:0]    func_q;
    logic [SW-1:0] sid_q;
    logic [63:0]   a_q;
    logic [31:0]   b_q;
    logic [63:0]   prod_q;
    logic [5:0]    cnt_q;
    logic          ready_q;
    logic [31:0]   resp_q;
    logic [3:0]    status_q;
    logic [31:0]   acc_q [NCTX];
    logic [2:0]    f;
    logic [SW-1:0] sid;
    logic [31:0]   old;
    logic [63:0]   pp;
    logic [63:0]   prod_d;
    logic [32:0]   sum;
    logic          mul_f;
    logic          fin;
    logic          we;
    logic [31:0]   resp_d;
    logic [31:0]   wdata;
    // In IDLE the live inputs drive the result path so non-multiply funcs finish in one cycle.
    always_comb begin
        f = state_q == IDLE ? cxu_func : func_q;
        sid = state_q == IDLE ? sid_in : sid_q;
        old = acc_q[sid];
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) pp = pp + (b_q[i] ? a_q << i : 64'd0);
        prod_d = prod_q + pp;
        sum = {1'b0, old} + {1'b0, prod_d[31:0]};
        mul_f = f == 3'd0 || f == 3'd1 || f == 3'd5;
        fin = state_q == IDLE ? cxu_valid && !mul_f : state_q == BUSY && cnt_q == 6'd0;
        resp_d = f == 3'd0 ? sum[31:0] : f == 3'd1 ? prod_d[31:0] : f == 3'd5 ? prod_d[63:32] :
                 f < 3'd5 ? old : 32'd0;
        we = fin && (f == 3'd0 || f == 3'd3 || f == 3'd4);
        wdata = f == 3'd0 ? sum[31:0] : f == 3'd3 ? cxu_data0 : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            func_q <= '0;
            sid_q <= '0;
            a_q <= '0;
            b_q <= '0;
            prod_q <= '0;
            cnt_q <= '0;
            ready_q <= 1'b0;
            resp_q <= '0;
            status_q <= '0;
            for (int i = 0; i < NCTX; i++) acc_q[i] <= '0;
        end else begin
            ready_q <= fin;
            if (fin) begin
                resp_q <= resp_d;
                status_q <= {2'b00, f == 3'd0 && sum[32], f > 3'd5};
            end
            if (we) acc_q[sid] <= wdata;
            case (state_q)
                IDLE: if (cxu_valid) begin
                    func_q <= cxu_func;
                    sid_q <= sid_in;
                    a_q <= {32'd0, cxu_data0};
                    b_q <= cxu_data1;
                    prod_q <= '0;
                    cnt_q <= 6'(CYC - 1);
                    state_q <= mul_f ? BUSY : DONE;
                end
                BUSY: begin
                    prod_q <= prod_d;
                    a_q <= a_q << BITS_PER_CYCLE;
                    b_q <= b_q >> BITS_PER_CYCLE;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cxu_ready = ready_q;
    assign cxu_response = resp_q;
    assign cxu_status = status_q;
endmodule

// File: tb/tb_cx_mac_cxu.sv
// tb_cx_mac_cxu: directed vector table plus reset-abort and back-to-back sequences for cx_mac_cxu.
module tb_cx_mac_cxu;
`ifdef CX_MAC_STATE_CTX_EN
    localparam bit CTX = 1'b1;
`else
    localparam bit CTX = 1'b0;
`endif
    localparam int ML = 1 + 32 / 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  func = '0;
    logic [31:0] d0 = '0;
    logic [31:0] d1 = '0;
    logic [1:0]  sid = '0;
    logic        ready;
    logic [31:0] resp;
    logic [3:0]  status;
    int checks = 0;
    int errors = 0;

    cx_mac_cxu #(.BITS_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .cxu_valid(valid), .cxu_func(func),
        .cxu_data0(d0), .cxu_data1(d1), .cx_state_id(sid),
        .cxu_ready(ready), .cxu_response(resp), .cxu_status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  s;
        logic [31:0] r;
        logic [3:0]  st;
        int          lat;
    } vec_t;
    vec_t v[$];

    function automatic vec_t mk(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [1:0] s,
                                logic [31:0] r, logic [3:0] st, int lat);
        vec_t x;
        x.f = f; x.a = a; x.b = b; x.s = s; x.r = r; x.st = st; x.lat = lat;
        return x;
    endfunction

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] s, output logic [31:0] r, output logic [3:0] st,
                       output int lat);
        func = f; d0 = a; d1 = b; sid = s; valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready && lat < 40);
        valid = 1'b0;
        r = resp;
        st = status;
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  st;
        int          lat;
        int          pulses;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_resp", resp, 32'd0);
        check("reset_status", 32'(status), 32'd0);
        rst = 1'b0;

        v.push_back(mk(3'd1, 32'h0001_0000, 32'h0001_0000, 2'd0, 32'h0000_0000, 4'd0, ML));
        v.push_back(mk(3'd5, 32'h0001_0000, 32'h0001_0000, 2'd0, 32'h0000_0001, 4'd0, ML));
        v.push_back(mk(3'd1, 32'h1234_5678, 32'h0000_0010, 2'd0, 32'h2345_6780, 4'd0, ML));
        v.push_back(mk(3'd5, 32'h1234_5678, 32'h0000_0010, 2'd0, 32'h0000_0001, 4'd0, ML));
        v.push_back(mk(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'h0000_0001, 4'd0, ML));
        v.push_back(mk(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFE, 4'd0, ML));
        v.push_back(mk(3'd1, 32'h0000_00FF, 32'h0000_0101, 2'd0, 32'h0000_FFFF, 4'd0, ML));
        v.push_back(mk(3'd5, 32'h8000_0000, 32'h8000_0000, 2'd0, 32'h4000_0000, 4'd0, ML));
        v.push_back(mk(3'd3, 32'hFFFF_FFFF, 32'd0, 2'd1, 32'h0, 4'd0, 1));
        v.push_back(mk(3'd0, 32'd1, 32'd1, 2'd1, 32'h0, 4'b0010, ML));
        v.push_back(mk(3'd2, 32'd0, 32'd0, 2'd0, 32'h0, 4'd0, 1));
        v.push_back(mk(3'd2, 32'd0, 32'd0, 2'd1, 32'h0, 4'd0, 1));
        v.push_back(mk(3'd7, 32'h1234, 32'd0, 2'd1, 32'h0, 4'b0001, 1));
        v.push_back(mk(3'd6, 32'h1234, 32'h5, 2'd1, 32'h0, 4'b0001, 1));
        v.push_back(mk(3'd2, 32'd0, 32'd0, 2'd1, 32'h0, 4'd0, 1));
        v.push_back(mk(3'd3, 32'h100, 32'd0, 2'd0, 32'h0, 4'd0, 1));
        v.push_back(mk(3'd3, 32'h55, 32'd0, 2'd3, CTX ? 32'h0 : 32'h100, 4'd0, 1));
        v.push_back(mk(3'd2, 32'd0, 32'd0, 2'd0, CTX ? 32'h100 : 32'h55, 4'd0, 1));
        v.push_back(mk(3'd0, 32'h10, 32'h10, 2'd0, CTX ? 32'h200 : 32'h155, 4'd0, ML));
        v.push_back(mk(3'd4, 32'd0, 32'd0, 2'd0, CTX ? 32'h200 : 32'h155, 4'd0, 1));
        v.push_back(mk(3'd2, 32'd0, 32'd0, 2'd0, 32'h0, 4'd0, 1));
        v.push_back(mk(3'd2, 32'd0, 32'd0, 2'd3, CTX ? 32'h55 : 32'h0, 4'd0, 1));
        v.push_back(mk(3'd7, 32'h1234, 32'd0, 2'd3, 32'h0, 4'b0001, 1));
        v.push_back(mk(3'd2, 32'd0, 32'd0, 2'd3, CTX ? 32'h55 : 32'h0, 4'd0, 1));
        v.push_back(mk(3'd0, 32'h7FFF_FFFF, 32'd2, 2'd3, CTX ? 32'h53 : 32'hFFFF_FFFE,
                       CTX ? 4'b0010 : 4'b0000, ML));

        foreach (v[i]) begin
            req(v[i].f, v[i].a, v[i].b, v[i].s, r, st, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
            check($sformatf("v%0d_resp", i), r, v[i].r);
            check($sformatf("v%0d_status", i), 32'(st), 32'(v[i].st));
            @(posedge clk); #1;
            check($sformatf("v%0d_pulse", i), 32'(ready), 32'd0);
        end

        // MAC abandoned by a reset in its fourth BUSY cycle
        func = 3'd0; d0 = 32'd3; d1 = 32'd5; sid = 2'd2; valid = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            pulses += int'(ready);
        end
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses += int'(ready);
        check("rst_resp", resp, 32'd0);
        repeat (15) begin
            @(posedge clk); #1;
            pulses += int'(ready);
        end
        check("rst_no_ready", 32'(pulses), 32'd0);
        req(3'd2, 32'd0, 32'd0, 2'd2, r, st, lat);
        check("rst_rdacc", r, 32'd0);
        check("rst_rdacc_lat", 32'(lat), 32'd1);
        @(posedge clk); #1;

        // Two MACs with valid held through DONE
        func = 3'd0; d0 = 32'd2; d1 = 32'd3; sid = 2'd0; valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready && lat < 40);
        check("b2b_lat1", 32'(lat), 32'(ML));
        check("b2b_resp1", resp, 32'd6);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready && lat < 40);
        valid = 1'b0;
        check("b2b_gap", 32'(lat), 32'd10);
        check("b2b_resp2", resp, 32'd12);
        check("b2b_status2", 32'(status), 32'd0);
        @(posedge clk); #1;
        check("b2b_pulse", 32'(ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
